// File: rtl/ram_writer.sv
// ---------------------------------------------------------------------------
// ram_writer
//
// Burst writer into a small on-chip RAM with an independent registered read
// port. A burst is requested in IDLE with start/start_addr/len. In WRITE the
// block presents wr_ready and stores one word per wr_valid cycle, advancing
// a wrapping write pointer. After the last word it spends one cycle in DONE
// (done pulse) and returns to IDLE.
//
// Ports
//   inclk       in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset; clears FSM, pointer,
//                    count, read register and every memory word
//   start       in   burst request, only honoured in IDLE with len != 0
//   start_addr  in   [AW-1:0] first write address of the burst
//   len         in   [AW:0]   burst length in words, 0..2**AW
//   wr_valid    in   writer-side data valid
//   wr_data     in   [DW-1:0] word to store
//   wr_ready    out  high in WRITE; a transfer is wr_valid & wr_ready
//   busy        out  high in WRITE and DONE
//   done        out  one-cycle pulse while in DONE
//   waddr       out  [AW-1:0] current write pointer
//   rd_addr     in   [AW-1:0] read address
//   q           out  [DW-1:0] registered read data, one-cycle latency
// ---------------------------------------------------------------------------
module ram_writer #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          inclk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] waddr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] q
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_waddr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_wr_ready;
  logic          w_busy;
  logic          w_done;
  logic          w_load;
  logic          w_xfer;

  // A zero-length request is dropped here so it never leaves IDLE.
  assign w_load = (r_state == S_IDLE) && start && (len != CNT_ZERO);
  assign w_xfer = w_wr_ready && wr_valid;

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr_ready = 1'b1;
        w_busy     = 1'b1;
        // Stalls (wr_valid low) simply hold here; there is no timeout.
        if (wr_valid && (r_count == CNT_ONE)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer, count, memory and read register
  always_ff @(posedge inclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_count <= '0;
      r_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      // Non-blocking read of r_mem returns the pre-write word on a
      // same-address read/write collision.
      r_q     <= r_mem[rd_addr];
      if (w_load) begin
        r_waddr <= start_addr;
        r_count <= len;
      end else if (w_xfer) begin
        r_mem[r_waddr] <= wr_data;
        // Pointer wraps naturally at 2**AW.
        r_waddr <= r_waddr + 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign wr_ready = w_wr_ready;
  assign busy     = w_busy;
  assign done     = w_done;
  assign waddr    = r_waddr;
  assign q        = r_q;

endmodule

// File: tb/tb_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_ram_writer
//
// Self-checking bench for ram_writer. A transaction-level reference model
// (array memory, burst bookkeeping with plain integers) predicts every
// output each cycle; directed bursts are followed by randomized traffic.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_writer;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          inclk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] waddr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] q;

  always #5 inclk = ~inclk;

  ram_writer #(.DW(DW), .AW(AW)) dut (
    .inclk      (inclk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .waddr      (waddr),
    .rd_addr    (rd_addr),
    .q          (q)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents plus burst bookkeeping
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known = 0;
  bit            m_act   = 0;
  bit            m_done  = 0;
  int            m_rem   = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] m_q     = '0;

  // Check outputs against the model, advance the model with the current
  // inputs, then let one clock cycle pass.
  task automatic tick();
    logic [DW-1:0] rd;
    if (m_known) begin
      chk("wr_ready", wr_ready, m_act);
      chk("busy",     busy,     m_act || m_done);
      chk("done",     done,     m_done);
      chk("waddr",    waddr,    m_ptr);
      chk("q",        q,        m_q);
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_act = 0; m_done = 0; m_rem = 0; m_ptr = 0; m_q = '0;
      m_known = 1;
    end else begin
      rd = m_mem[rd_addr];
      if (m_done) begin
        m_done = 0;
      end else if (m_act) begin
        if (wr_valid) begin
          m_mem[m_ptr] = wr_data;
          m_ptr = (m_ptr + 1) % DEPTH;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_act  = 0;
            m_done = 1;
          end
        end
      end else if (start && len != 0) begin
        m_act = 1;
        m_ptr = int'(start_addr);
        m_rem = int'(len);
      end
      m_q = rd;
    end
    @(posedge inclk);
    @(negedge inclk);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    @(negedge inclk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state, then read every address back as zero
    chk("rst_busy",  busy, 1'b0);
    chk("rst_waddr", waddr, 0);
    read_all();

    // Full 16-word burst from 0, data = addr ^ F, valid held high
    start = 1'b1; start_addr = 4'd0; len = 5'd16;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(i) ^ 4'hF;
      chk("full_ready", wr_ready, 1'b1);
      tick();
    end
    wr_valid = 1'b0;
    chk("full_done", done, 1'b1);
    tick();
    read_all();
    rd_addr = 4'd5;
    tick();
    chk("full_rb5", q, 4'hA);

    // Wrapping burst: 14, 15, 0, 1
    start = 1'b1; start_addr = 4'd14; len = 5'd4;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("wrap_waddr", waddr, 2);
    chk("wrap_done",  done, 1'b1);
    tick();
    rd_addr = 4'd0;
    tick();
    tick();
    chk("wrap_rb0", q, 4'd3);
    read_all();

    // len=3 with stalls and an ignored mid-burst start
    start = 1'b1; start_addr = 4'd3; len = 5'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = (i == 0 || i == 3 || i == 5);
      wr_data  = 4'($urandom);
      if (i == 2) begin
        start = 1'b1; start_addr = 4'd9; len = 5'd7;
      end else begin
        start = 1'b0;
      end
      chk("stall_busy", busy, 1'b1);
      tick();
    end
    wr_valid = 1'b0; start = 1'b0;
    chk("stall_done", done, 1'b1);
    tick();
    read_all();

    // Zero-length request is ignored
    start = 1'b1; start_addr = 4'd7; len = 5'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", busy, 1'b0);
    tick();
    tick();
    read_all();

    // Reset mid-burst after 2 of 5 transfers, then restart immediately
    start = 1'b1; start_addr = 4'd4; len = 5'd5;
    tick();
    start = 1'b0;
    wr_valid = 1'b1; wr_data = 4'h6; tick();
    wr_valid = 1'b1; wr_data = 4'h9; tick();
    rst = 1'b1; start = 1'b1; wr_data = 4'hC;
    tick();
    rst = 1'b0; wr_valid = 1'b0;
    chk("abort_busy", busy, 1'b0);
    start = 1'b1; start_addr = 4'd2; len = 5'd2;
    tick();
    start = 1'b0;
    chk("restart_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_data = 4'h5; tick();
    wr_valid = 1'b1; wr_data = 4'h7; tick();
    wr_valid = 1'b0;
    tick();
    read_all();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 3) == 0);
      start_addr = AW'($urandom);
      len        = (AW+1)'($urandom_range(0, 16));
      wr_valid   = ($urandom_range(0, 2) != 0);
      wr_data    = DW'($urandom);
      rd_addr    = AW'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; wr_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 SHALL have parameter DW, default 4, data word width in bits.
REQ-002 SHALL have parameter AW, default 4, address width in bits; depth = 2**AW (16 words).
REQ-003 SHALL have port inclk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  AW  first write address of the burst.
REQ-007 SHALL have port len  input  AW+1  burst length in words, 0..16.
REQ-008 SHALL have port wr_valid  input  1  writer-side data valid.
REQ-009 SHALL have port wr_data  input  DW  word to store.
REQ-010 SHALL have port wr_ready  output  1  block accepts wr_data this cycle.
REQ-011 SHALL have port busy  output  1  high in WRITE and DONE states.
REQ-012 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-013 SHALL have port waddr  output  AW  current write pointer.
REQ-014 SHALL have port rd_addr  input  AW  read address.
REQ-015 SHALL have port q  output  DW  registered read data.

Function
REQ-016 SHALL contain a 2**AW x DW memory with one write port (internal) and one read port (rd_addr/q).
REQ-017 SHALL implement states IDLE, WRITE, DONE.
REQ-018 IDLE: wr_ready=0, busy=0; start=1 with len!=0 -> WRITE next cycle, waddr<=start_addr, remaining count<=len.
REQ-019 IDLE: start=1 with len=0 SHALL be ignored (stay IDLE, no done pulse, memory unchanged).
REQ-020 WRITE: wr_ready=1 combinationally from state; a transfer occurs on a cycle with wr_valid=1 and wr_ready=1.
REQ-021 On transfer: mem[waddr]<=wr_data, waddr<=waddr+1 mod 2**AW (15 wraps to 0), count<=count-1.
REQ-022 wr_valid=0 cycles in WRITE SHALL stall: no write, waddr and count held, no timeout.
REQ-023 Transfer with count=1 SHALL move to DONE next cycle; exactly len words written.
REQ-024 DONE: done=1, wr_ready=0, busy=1 for exactly one cycle, then IDLE.
REQ-025 start asserted in WRITE or DONE SHALL be ignored; start_addr/len only sampled in IDLE.
REQ-026 len=16 SHALL write all 16 locations once, wrapping past 15 when start_addr!=0.
REQ-027 Read port: q<=mem[rd_addr] every cycle, one-cycle latency, independent of state.
REQ-028 Read and write to same address in same cycle: q SHALL return the old (pre-write) contents.
REQ-029 wr_valid while wr_ready=0 SHALL have no effect.

Reset
REQ-030 rst=1 at a rising edge SHALL force state IDLE, waddr=0, count=0, done=0, q=0, all memory words=0.
REQ-031 rst SHALL take priority over start and any transfer in the same cycle.
REQ-032 rst mid-burst SHALL abort: no done pulse, partially written words cleared to 0.
REQ-033 After rst deasserts, block SHALL accept start on the first following cycle.

Verification
REQ-034 Reset then read addr 0..15 -> q=0 for every address, one cycle after each rd_addr.
REQ-035 start, start_addr=0, len=16, wr_data=addr^4'hF with wr_valid held high -> 16 transfers on 16 consecutive cycles, done pulse 1 cycle later, readback mem[i]=~i.
REQ-036 start_addr=14, len=4, data 1,2,3,4 -> mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4, waddr=2 in DONE; other words unchanged.
REQ-037 len=3 with wr_valid toggling 1,0,0,1,0,1 -> writes only on valid cycles, done after third transfer, busy high throughout, start pulse mid-burst ignored.
REQ-038 start with len=0 -> no busy, no done, memory unchanged.
REQ-039 rst asserted after 2 of 5 transfers -> IDLE next cycle, no done, all words read 0, new burst accepted next cycle.
